// File: rtl/miriscv_data_arb_if.sv
// rtl/miriscv_data_arb_if.sv - requester-side data bus bundle for miriscv_data_arb
//
// One instance carries a single requester's request/grant/response signals.
//   req, lock, we, be[3:0], addr[31:0], wdata[31:0] : requester -> arbiter
//   gnt                                             : arbiter -> requester, same cycle
//   rvalid, rdata[31:0], err                        : arbiter -> requester, one cycle after gnt
// Modports: master (requester side), slave (arbiter side).

interface miriscv_data_arb_if;
  logic        req;
  logic        lock;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, lock, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, lock, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/miriscv_data_arb.sv
// rtl/miriscv_data_arb.sv - two-requester arbiter for the miriscv_ram data port
//
// Shares the RAM data port between requester 0 (LSU) and requester 1 (DMA/loader).
// Grants are combinational, responses return one cycle later to the owning
// requester only. Out-of-range accesses are granted but never reach the RAM and
// come back with err=1, rdata=0. A requester granted with lock=1 keeps exclusive
// ownership until it deasserts lock.
//
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   m0, m1                  : requester buses (miriscv_data_arb_if.slave)
//   ram_req_o .. ram_wdata_o: RAM data port drive
//   ram_rdata_i             : RAM read data, valid one cycle after ram_req_o
//
// Build option: MIRISCV_ARB_RR_EN selects round-robin priority between the
// requesters in IDLE; without it requester 0 always wins a conflict.

module miriscv_data_arb #(
  parameter int unsigned RAM_SIZE = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  miriscv_data_arb_if.slave   m0,
  miriscv_data_arb_if.slave   m1,
  output logic                ram_req_o,
  output logic                ram_we_o,
  output logic [3:0]          ram_be_o,
  output logic [31:0]         ram_addr_o,
  output logic [31:0]         ram_wdata_o,
  input  logic [31:0]         ram_rdata_i
);

  localparam logic [31:0] RAM_LIMIT = 32'(RAM_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic prio;
  logic gnt0, gnt1, grant_any, in_range;

  // Response bookkeeping for the access granted in the previous cycle.
  logic rvalid_q, owner_q, in_range_q, we_q;
  logic resp0, resp1, rdata_ok;

`ifdef MIRISCV_ARB_RR_EN
  logic prio_q, prio_d;

  // Only IDLE arbitration moves the pointer; it then points away from the winner.
  always_comb begin
    prio_d = prio_q;
    if (state_q == IDLE && grant_any) begin
      prio_d = gnt0;
    end
  end

  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  // Grant decision.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0.req && m1.req) begin
          gnt0 = ~prio;
          gnt1 = prio;
        end else begin
          gnt0 = m0.req;
          gnt1 = m1.req;
        end
      end
      LOCK0:   gnt0 = m0.req;
      LOCK1:   gnt1 = m1.req;
      default: ;
    endcase
  end

  assign grant_any = gnt0 | gnt1;

  // Lock tracking. A locked owner leaves as soon as it drops lock, whether or
  // not it is requesting in that cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt0 && m0.lock) begin
          state_d = LOCK0;
        end else if (gnt1 && m1.lock) begin
          state_d = LOCK1;
        end
      end
      LOCK0:   if (!m0.lock) state_d = IDLE;
      LOCK1:   if (!m1.lock) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM port mux: requester 1 only when it holds the grant.
  assign ram_we_o    = gnt1 ? m1.we    : m0.we;
  assign ram_be_o    = gnt1 ? m1.be    : m0.be;
  assign ram_addr_o  = gnt1 ? m1.addr  : m0.addr;
  assign ram_wdata_o = gnt1 ? m1.wdata : m0.wdata;

  assign in_range  = ram_addr_o < RAM_LIMIT;
  assign ram_req_o = grant_any & in_range;

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rvalid_q   <= 1'b0;
      owner_q    <= 1'b0;
      in_range_q <= 1'b0;
      we_q       <= 1'b0;
`ifdef MIRISCV_ARB_RR_EN
      prio_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rvalid_q   <= grant_any;
      owner_q    <= gnt1;
      in_range_q <= in_range;
      we_q       <= ram_we_o;
`ifdef MIRISCV_ARB_RR_EN
      prio_q     <= prio_d;
`endif
    end
  end

  // Responses. RAM data is passed through only for in-range reads; writes and
  // suppressed accesses return zero.
  assign resp0    = rvalid_q & ~owner_q;
  assign resp1    = rvalid_q &  owner_q;
  assign rdata_ok = in_range_q & ~we_q;

  assign m0.rvalid = resp0;
  assign m1.rvalid = resp1;
  assign m0.err    = resp0 & ~in_range_q;
  assign m1.err    = resp1 & ~in_range_q;
  assign m0.rdata  = (resp0 && rdata_ok) ? ram_rdata_i : 32'h0;
  assign m1.rdata  = (resp1 && rdata_ok) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_miriscv_data_arb.sv
// tb/tb_miriscv_data_arb.sv - directed vector bench for miriscv_data_arb

module tb_miriscv_data_arb;

`ifdef MIRISCV_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        r0, l0, w0;
    logic [31:0] a0, d0;
    logic        r1, l1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, rq, v0, v1, e0, e1;
    logic [31:0] rd0, rd1;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        load;
  logic        ram_req, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [31:0] mem [0:63];

  int checks;
  int errors;

  vec_t vecs[$];

  miriscv_data_arb_if m0_if ();
  miriscv_data_arb_if m1_if ();

  miriscv_data_arb #(.RAM_SIZE(256)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m0         (m0_if),
    .m1         (m1_if),
    .ram_req_o  (ram_req),
    .ram_we_o   (ram_we),
    .ram_be_o   (ram_be),
    .ram_addr_o (ram_addr),
    .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: 64 words, address aliasing on bits [7:2], one-cycle read latency.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'hDEADBEEF;
      mem[8]  <= 32'h0BADF00D;
      mem[63] <= 32'hCAFE0063;
      ram_rdata <= 32'h0;
    end else if (ram_req) begin
      ram_rdata <= mem[ram_addr[7:2]];
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  function automatic vec_t mk(
    input logic rst_v,
    input logic r0, input logic l0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
    input logic r1, input logic l1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
    input logic g0, input logic g1, input logic rq,
    input logic v0, input logic v1, input logic e0, input logic e1,
    input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.rst = rst_v;
    v.r0 = r0; v.l0 = l0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.l1 = l1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.rq = rq;
    v.v0 = v0; v.v1 = v1; v.e0 = e0; v.e1 = e1;
    v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic step(input vec_t v, input string name, input int idx);
    logic [6:0]  got_c, exp_c;
    logic [31:0] exp_addr;
    logic        exp_we;
    @(negedge clk);
    rst         = v.rst;
    m0_if.req   = v.r0; m0_if.lock = v.l0; m0_if.we = v.w0;
    m0_if.addr  = v.a0; m0_if.wdata = v.d0; m0_if.be = 4'hF;
    m1_if.req   = v.r1; m1_if.lock = v.l1; m1_if.we = v.w1;
    m1_if.addr  = v.a1; m1_if.wdata = v.d1; m1_if.be = 4'hF;
    #1;
    got_c = {m0_if.gnt, m1_if.gnt, ram_req, m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err};
    exp_c = {v.g0, v.g1, v.rq, v.v0, v.v1, v.e0, v.e1};
    checks++;
    if (got_c !== exp_c) begin
      errors++;
      $display("FAIL %s[%0d] g0,g1,rq,v0,v1,e0,e1 got %b want %b", name, idx, got_c, exp_c);
    end
    checks++;
    if (m0_if.rdata !== v.rd0) begin
      errors++;
      $display("FAIL %s[%0d] m0_rdata got %h want %h", name, idx, m0_if.rdata, v.rd0);
    end
    checks++;
    if (m1_if.rdata !== v.rd1) begin
      errors++;
      $display("FAIL %s[%0d] m1_rdata got %h want %h", name, idx, m1_if.rdata, v.rd1);
    end
    if (v.rq) begin
      exp_addr = v.g1 ? v.a1 : v.a0;
      exp_we   = v.g1 ? v.w1 : v.w0;
      checks++;
      if (ram_addr !== exp_addr || ram_we !== exp_we) begin
        errors++;
        $display("FAIL %s[%0d] ram addr/we got %h/%b want %h/%b",
                 name, idx, ram_addr, ram_we, exp_addr, exp_we);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst  = 1'b1;
    load = 1'b1;
    m0_if.req = 0; m0_if.lock = 0; m0_if.we = 0; m0_if.be = 4'hF; m0_if.addr = 0; m0_if.wdata = 0;
    m1_if.req = 0; m1_if.lock = 0; m1_if.we = 0; m1_if.be = 4'hF; m1_if.addr = 0; m1_if.wdata = 0;
    @(negedge clk);
    @(negedge clk);
    load = 1'b0;

    //            rst r0 l0 w0 a0        d0             r1 l1 w1 a1        d1            g0   g1   rq v0   v1   e0 e1 rd0                      rd1
    vecs.push_back(mk(1, 0,0,0,32'h0,   32'h0,         0,0,0,32'h0,   32'h0,        0,   0,   0, 0,   0,   0,0, 32'h0,                   32'h0));
    vecs.push_back(mk(0, 1,0,0,32'h10,  32'h0,         0,0,0,32'h0,   32'h0,        1,   0,   1, 0,   0,   0,0, 32'h0,                   32'h0));
    vecs.push_back(mk(0, 0,0,0,32'h0,   32'h0,         1,0,0,32'h10,  32'h0,        0,   1,   1, 1,   0,   0,0, 32'hDEADBEEF,            32'h0));
    vecs.push_back(mk(0, 1,0,0,32'h10,  32'h0,         1,0,0,32'h10,  32'h0,        1,   0,   1, 0,   1,   0,0, 32'h0,                   32'hDEADBEEF));
    vecs.push_back(mk(0, 1,0,0,32'h10,  32'h0,         1,0,0,32'h10,  32'h0,        !RR, RR,  1, 1,   0,   0,0, 32'hDEADBEEF,            32'h0));
    vecs.push_back(mk(0, 1,0,0,32'h10,  32'h0,         1,0,0,32'h10,  32'h0,        1,   0,   1, !RR, RR,  0,0, RR ? 32'h0 : 32'hDEADBEEF, RR ? 32'hDEADBEEF : 32'h0));
    vecs.push_back(mk(0, 1,0,0,32'h10,  32'h0,         1,0,0,32'h10,  32'h0,        !RR, RR,  1, 1,   0,   0,0, 32'hDEADBEEF,            32'h0));
    vecs.push_back(mk(0, 0,0,0,32'h0,   32'h0,         0,0,0,32'h0,   32'h0,        0,   0,   0, !RR, RR,  0,0, RR ? 32'h0 : 32'hDEADBEEF, RR ? 32'hDEADBEEF : 32'h0));
    // m1 locked write burst while m0 waits
    vecs.push_back(mk(0, 0,0,0,32'h0,   32'h0,         1,1,1,32'h24,  32'hA5A50001, 0,   1,   1, 0,   0,   0,0, 32'h0,                   32'h0));
    vecs.push_back(mk(0, 1,0,0,32'h10,  32'h0,         1,1,1,32'h28,  32'h00000002, 0,   1,   1, 0,   1,   0,0, 32'h0,                   32'h0));
    vecs.push_back(mk(0, 1,0,0,32'h10,  32'h0,         1,0,1,32'h2C,  32'h00000003, 0,   1,   1, 0,   1,   0,0, 32'h0,                   32'h0));
    vecs.push_back(mk(0, 1,0,0,32'h10,  32'h0,         0,0,0,32'h0,   32'h0,        1,   0,   1, 0,   1,   0,0, 32'h0,                   32'h0));
    vecs.push_back(mk(0, 0,0,0,32'h0,   32'h0,         1,0,0,32'h28,  32'h0,        0,   1,   1, 1,   0,   0,0, 32'hDEADBEEF,            32'h0));
    vecs.push_back(mk(0, 0,0,0,32'h0,   32'h0,         0,0,0,32'h0,   32'h0,        0,   0,   0, 0,   1,   0,0, 32'h0,                   32'h00000002));
    // out-of-range read and write (0x110 would alias onto 0x10 if it reached RAM)
    vecs.push_back(mk(0, 1,0,0,32'h100, 32'h0,         0,0,0,32'h0,   32'h0,        1,   0,   0, 0,   0,   0,0, 32'h0,                   32'h0));
    vecs.push_back(mk(0, 1,0,1,32'h110, 32'hFFFFFFFF,  0,0,0,32'h0,   32'h0,        1,   0,   0, 1,   0,   1,0, 32'h0,                   32'h0));
    vecs.push_back(mk(0, 1,0,0,32'h10,  32'h0,         0,0,0,32'h0,   32'h0,        1,   0,   1, 1,   0,   1,0, 32'h0,                   32'h0));
    vecs.push_back(mk(0, 0,0,0,32'h0,   32'h0,         0,0,0,32'h0,   32'h0,        0,   0,   0, 1,   0,   0,0, 32'hDEADBEEF,            32'h0));
    // alternating read/write on 0x20, then top in-range word and locked-burst readback
    vecs.push_back(mk(0, 1,0,0,32'h20,  32'h0,         0,0,0,32'h0,   32'h0,        1,   0,   1, 0,   0,   0,0, 32'h0,                   32'h0));
    vecs.push_back(mk(0, 0,0,0,32'h0,   32'h0,         1,0,1,32'h20,  32'h12345678, 0,   1,   1, 1,   0,   0,0, 32'h0BADF00D,            32'h0));
    vecs.push_back(mk(0, 1,0,0,32'h20,  32'h0,         0,0,0,32'h0,   32'h0,        1,   0,   1, 0,   1,   0,0, 32'h0,                   32'h0));
    vecs.push_back(mk(0, 0,0,0,32'h0,   32'h0,         1,0,0,32'hFC,  32'h0,        0,   1,   1, 1,   0,   0,0, 32'h12345678,            32'h0));
    vecs.push_back(mk(0, 0,0,0,32'h0,   32'h0,         1,0,0,32'h24,  32'h0,        0,   1,   1, 0,   1,   0,0, 32'h0,                   32'hCAFE0063));
    vecs.push_back(mk(0, 0,0,0,32'h0,   32'h0,         0,0,0,32'h0,   32'h0,        0,   0,   0, 0,   1,   0,0, 32'h0,                   32'hA5A50001));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], "vec", i);

    // Reset while m0 holds the lock: the reset-cycle grant gets no response and
    // m1 is granted straight away afterwards.
    step(mk(0, 1,1,0,32'h10, 32'h0, 0,0,0,32'h0,  32'h0, 1,0,1, 0,0,0,0, 32'h0, 32'h0), "rst_lock", 0);
    step(mk(1, 1,1,0,32'h10, 32'h0, 1,0,0,32'h10, 32'h0, 1,0,1, 1,0,0,0, 32'hDEADBEEF, 32'h0), "rst_lock", 1);
    step(mk(0, 0,1,0,32'h0,  32'h0, 1,0,0,32'h24, 32'h0, 0,1,1, 0,0,0,0, 32'h0, 32'h0), "rst_lock", 2);
    step(mk(0, 0,0,0,32'h0,  32'h0, 0,0,0,32'h0,  32'h0, 0,0,0, 0,1,0,0, 32'h0, 32'hA5A50001), "rst_lock", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
